// File: rtl/map_streamer.sv
// map_streamer: streams the map table and then the ship-health table from a
// synchronous ROM to a UART transmitter, one byte per handshake. After the
// last byte it listens for result bytes and keeps saturating statistics.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle request: clear statistics, stream the table
//   rom_addr / rom_data  synchronous ROM port (data one cycle after address)
//   tx_data / tx_start   byte and one-cycle send pulse to the UART
//   tx_busy              UART busy flag
//   rx_byte_ready/rx_byte  received result byte strobe and value
//   streaming/listening  phase indicators
//   hit_cnt..err_cnt     saturating 8-bit result counters
//   game_over            sticky: sunk_cnt reached SHIPS
//   tx_fault             sticky: tx_busy never rose after a tx_start
module map_streamer #(
  parameter int MAP_BYTES    = 128,
  parameter int HEALTH_BYTES = 16,
  parameter int SHIPS        = 5,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       rx_byte_ready,
  input  logic [7:0] rx_byte,
  output logic       streaming,
  output logic       listening,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt,
  output logic [7:0] rep_cnt,
  output logic [7:0] sunk_cnt,
  output logic [7:0] err_cnt,
  output logic       game_over,
  output logic       tx_fault
);

  localparam int         N        = MAP_BYTES + HEALTH_BYTES;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);
  localparam logic [7:0] SHIPS_B  = 8'(SHIPS);
  localparam int         TW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, WAIT_BUSY, WAIT_DONE, LISTEN
  } state_t;

  state_t        state, state_n;
  logic [7:0]    idx;
  logic [TW-1:0] tmr;
  logic          start_ok;
  logic          timeout;
  logic          last_byte;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start_ok  = start && ((state == IDLE) || (state == LISTEN));
  assign timeout   = (state == WAIT_BUSY) && !tx_busy && (tmr == TMR_LAST);
  assign last_byte = (idx == LAST_IDX);

  assign rom_addr  = idx;
  assign streaming = (state == FETCH) || (state == LOAD) || (state == SEND) ||
                     (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign listening = (state == LISTEN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = FETCH;
      FETCH:     state_n = LOAD;
      LOAD:      state_n = SEND;
      SEND:      if (!tx_busy) state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_n = WAIT_DONE;
        else if (timeout) state_n = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_n = last_byte ? LISTEN : FETCH;
      LISTEN:    if (start) state_n = FETCH;
      default:   state_n = IDLE;
    endcase
  end

  // tx_start is registered so the pulse coincides with the first WAIT_BUSY
  // cycle, three cycles after start is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      tmr       <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      tx_fault  <= 1'b0;
      game_over <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      rep_cnt   <= '0;
      sunk_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      tx_start <= (state == SEND) && !tx_busy;

      if (start_ok)
        idx <= '0;
      else if ((state == WAIT_DONE) && !tx_busy && !last_byte)
        idx <= idx + 8'd1;

      if (state == LOAD) tx_data <= rom_data;

      if (state == SEND)           tmr <= '0;
      else if (state == WAIT_BUSY) tmr <= tmr + TW'(1);

      if (start_ok)     tx_fault <= 1'b0;
      else if (timeout) tx_fault <= 1'b1;

      // Registered off the counter, so it lags sunk_cnt by one cycle.
      if (start_ok)                  game_over <= 1'b0;
      else if (sunk_cnt >= SHIPS_B)  game_over <= 1'b1;

      if (start_ok) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
        rep_cnt  <= '0;
        sunk_cnt <= '0;
        err_cnt  <= '0;
      end else if ((state == LISTEN) && rx_byte_ready) begin
        case (rx_byte)
          8'h48:   hit_cnt  <= sat_inc(hit_cnt);
          8'h4D:   miss_cnt <= sat_inc(miss_cnt);
          8'h52:   rep_cnt  <= sat_inc(rep_cnt);
          8'h53:   sunk_cnt <= sat_inc(sunk_cnt);
          default: err_cnt  <= sat_inc(err_cnt);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_map_streamer.sv
// Self-checking bench for map_streamer: ROM model (byte = addr ^ 8'hA5),
// UART model with a 10-cycle busy period, and a queue of expected tx bytes
// that is popped on every observed tx_start.
module tb_map_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       rx_byte_ready = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       streaming, listening;
  logic [7:0] hit_cnt, miss_cnt, rep_cnt, sunk_cnt, err_cnt;
  logic       game_over, tx_fault;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];
  int e_hit, e_miss, e_rep, e_sunk, e_err;

  logic uart_dead = 1'b0;
  int   busy_cnt = 0;

  map_streamer #(.MAP_BYTES(128), .HEALTH_BYTES(16), .SHIPS(5), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_byte_ready(rx_byte_ready), .rx_byte(rx_byte),
    .streaming(streaming), .listening(listening),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .rep_cnt(rep_cnt),
    .sunk_cnt(sunk_cnt), .err_cnt(err_cnt),
    .game_over(game_over), .tx_fault(tx_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr ^ 8'hA5;

  always @(posedge clk) begin
    if (tx_start && !uart_dead) busy_cnt <= 10;
    else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every tx_start pops the expected byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      logic [7:0] e;
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_tx_start: observed data %0h expected no pulse", tx_data);
      end else begin
        e = exp_q.pop_front();
        assert (tx_data === e) else begin
          errors++;
          $error("FAIL tx_data: observed %0h expected %0h", tx_data, e);
        end
      end
    end
  end

  task automatic model_clear();
    e_hit = 0; e_miss = 0; e_rep = 0; e_sunk = 0; e_err = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_hit"},  {24'd0, hit_cnt},  e_hit);
    check({tag, "_miss"}, {24'd0, miss_cnt}, e_miss);
    check({tag, "_rep"},  {24'd0, rep_cnt},  e_rep);
    check({tag, "_sunk"}, {24'd0, sunk_cnt}, e_sunk);
    check({tag, "_err"},  {24'd0, err_cnt},  e_err);
  endtask

  // Drive one rx strobe; the model counts it only when the DUT is listening.
  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    if (listening === 1'b1) begin
      case (b)
        8'h48:   e_hit  = sat(e_hit);
        8'h4D:   e_miss = sat(e_miss);
        8'h52:   e_rep  = sat(e_rep);
        8'h53:   e_sunk = sat(e_sunk);
        default: e_err  = sat(e_err);
      endcase
    end
    rx_byte = b;
    rx_byte_ready = 1'b1;
    @(negedge clk);
    rx_byte_ready = 1'b0;
  endtask

  // Pulse start (optionally with a coincident 'H'), load the scoreboard and
  // check that the first tx_start arrives three cycles after start is sampled.
  task automatic do_start(input int nbytes, input logic with_rx);
    @(negedge clk);
    for (int a = 0; a < nbytes; a++) exp_q.push_back(8'(a) ^ 8'hA5);
    model_clear();
    start = 1'b1;
    if (with_rx) begin rx_byte = 8'h48; rx_byte_ready = 1'b1; end
    @(negedge clk);
    start = 1'b0;
    rx_byte_ready = 1'b0;
    check("streaming_after_start", {31'd0, streaming}, 1);
    check("txs_lat1", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("txs_lat2", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("txs_lat3", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("txs_lat4", {31'd0, tx_start}, 1);
  endtask

  task automatic wait_listen(input string tag);
    for (int k = 0; k < 4000 && listening !== 1'b1; k++) @(negedge clk);
    check(tag, {31'd0, listening}, 1);
  endtask

  initial begin
    int base;
    model_clear();

    // Reset state
    #2;
    check("rst_rom_addr", {24'd0, rom_addr}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_flags", {28'd0, streaming, listening, game_over, tx_fault}, 0);
    check_counts("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Full stream; a start and an rx strobe mid-stream must be ignored
    base = pulses;
    do_start(144, 1'b0);
    repeat (40) @(negedge clk);
    send_rx(8'h48);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_listen("listen_after_stream");
    check("stream_pulses", pulses - base, 144);
    check("stream_queue_empty", exp_q.size(), 0);
    check_counts("during_stream");

    // Result sequence and game_over timing
    send_rx(8'h48); send_rx(8'h48); send_rx(8'h4D); send_rx(8'h52);
    send_rx(8'h53); send_rx(8'h53); send_rx(8'h53); send_rx(8'h53);
    check("go_before_5th", {31'd0, game_over}, 0);
    send_rx(8'h53);
    check("sunk_at_5th", {24'd0, sunk_cnt}, 5);
    check("go_same_cycle", {31'd0, game_over}, 0);
    @(negedge clk);
    check("go_next_cycle", {31'd0, game_over}, 1);
    send_rx(8'h00);
    check_counts("results");

    // Saturation
    for (int k = 0; k < 300; k++) send_rx(8'h4D);
    check_counts("saturate");
    check("miss_255", {24'd0, miss_cnt}, 255);
    check("go_sticky", {31'd0, game_over}, 1);
    check("still_listening", {31'd0, listening}, 1);

    // start coincident with 'H' in LISTEN: start wins
    base = pulses;
    do_start(144, 1'b1);
    check_counts("start_wins");
    check("go_cleared", {31'd0, game_over}, 0);

    // Async reset at byte 50, then restart
    for (int k = 0; k < 2000 && pulses < base + 50; k++) @(negedge clk);
    check("reached_byte50", pulses - base, 50);
    #2 rst = 1'b1;
    #1;
    check("abort_streaming", {31'd0, streaming}, 0);
    check("abort_rom_addr", {24'd0, rom_addr}, 0);
    check("abort_tx_data", {24'd0, tx_data}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    base = pulses;
    do_start(144, 1'b0);
    wait_listen("listen_after_restart");
    check("restart_pulses", pulses - base, 144);

    // Transmitter handshake timeout
    uart_dead = 1'b1;
    base = pulses;
    do_start(1, 1'b0);
    repeat (15) @(negedge clk);
    check("fault_not_yet", {30'd0, streaming, tx_fault}, 2'b10);
    @(negedge clk);
    check("fault_set", {29'd0, streaming, listening, tx_fault}, 3'b001);
    repeat (40) @(negedge clk);
    check("fault_single_pulse", pulses - base, 1);
    uart_dead = 1'b0;

    // start clears the fault
    do_start(144, 1'b0);
    check("fault_cleared", {31'd0, tx_fault}, 0);
    wait_listen("listen_final");
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_streamer.md
MAP_STREAMER -- requirements
Module: map_streamer

Interface
REQ-001 Parameter MAP_BYTES, default 128, number of map-cell bytes sent first.
REQ-002 Parameter HEALTH_BYTES, default 16, number of ship-health bytes sent after the map.
REQ-003 Parameter SHIPS, default 5, sunk count that ends the game.
REQ-004 Parameter BUSY_TIMEOUT, default 16, maximum cycles to wait for tx_busy to rise after tx_start.
REQ-005 clk  in  1  system clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to stream the full table and clear the statistics.
REQ-008 rom_addr  out  8  address into the synchronous table ROM; data is valid one cycle after the address.
REQ-009 rom_data  in  8  table byte returned by the ROM.
REQ-010 tx_data  out  8  byte offered to the UART transmitter.
REQ-011 tx_start  out  1  one-cycle send pulse to the UART transmitter.
REQ-012 tx_busy  in  1  transmitter busy flag from the UART.
REQ-013 rx_byte_ready  in  1  one-cycle strobe that a received byte is valid.
REQ-014 rx_byte  in  8  received result byte.
REQ-015 streaming  out  1  high while table bytes are being sent.
REQ-016 listening  out  1  high while the block is counting result bytes.
REQ-017 hit_cnt, miss_cnt, rep_cnt, sunk_cnt, err_cnt  out  8 each  result statistics.
REQ-018 game_over  out  1  sunk_cnt has reached SHIPS.
REQ-019 tx_fault  out  1  sticky flag: the transmitter handshake timed out.

Function
REQ-020 FSM states: IDLE, FETCH, LOAD, SEND, WAIT_BUSY, WAIT_DONE, LISTEN.
REQ-021 Total byte count N = MAP_BYTES + HEALTH_BYTES (default 144); byte index i runs 0..N-1 and rom_addr = i.
REQ-022 IDLE or LISTEN with start=1: clear i and all five counters, clear game_over and tx_fault, go to FETCH.
REQ-023 FETCH: drive rom_addr=i for one cycle, then go to LOAD.
REQ-024 LOAD: capture rom_data into tx_data, then go to SEND.
REQ-025 SEND: if tx_busy=0, assert tx_start for exactly one cycle and go to WAIT_BUSY; otherwise hold in SEND.
REQ-026 First tx_start fires 3 cycles after start is sampled, given tx_busy=0.
REQ-027 WAIT_BUSY: go to WAIT_DONE on tx_busy=1.
REQ-028 WAIT_BUSY timeout: after BUSY_TIMEOUT cycles without tx_busy=1, set tx_fault and go to IDLE.
REQ-029 WAIT_DONE: on tx_busy=0, if i=N-1 go to LISTEN; otherwise i<=i+1 and go to FETCH.
REQ-030 tx_data stays stable from LOAD until the next LOAD.
REQ-031 streaming=1 in FETCH, LOAD, SEND, WAIT_BUSY and WAIT_DONE.
REQ-032 rx_byte_ready during streaming or IDLE is ignored; no counter changes.
REQ-033 start during streaming is ignored.
REQ-034 LISTEN, on rx_byte_ready, by rx_byte:
  - 8'h48 'H': hit_cnt +1
  - 8'h4D 'M': miss_cnt +1
  - 8'h52 'R': rep_cnt +1
  - 8'h53 'S': sunk_cnt +1
  - any other value: err_cnt +1
REQ-035 All counters saturate at 255; there is no wrap-around.
REQ-036 game_over is registered: it goes high the cycle after sunk_cnt becomes >= SHIPS, then stays high until start or rst.
REQ-037 LISTEN persists after game_over; counting continues.
REQ-038 start and rx_byte_ready in the same LISTEN cycle: start wins; counters clear and the byte is dropped.

Reset
REQ-039 rst=1 forces, asynchronously:
  - state IDLE, i=0
  - rom_addr=0, tx_data=0, tx_start=0
  - all counters 0
  - game_over=0, tx_fault=0
  - streaming=0, listening=0
REQ-040 rst mid-stream aborts immediately; no further tx_start until a new start.

Verification
REQ-041 Start with a model UART that has a 10-cycle busy period and a ROM with byte=addr^8'hA5 -> exactly 144 tx_start pulses; tx_data sequence is 8'hA5, 8'hA4, ... through addr 143; listening=1 after the last busy falls.
REQ-042 In LISTEN, inject H,H,M,R,S,S,S,S,S,8'h00 -> hit_cnt=2, miss_cnt=1, rep_cnt=1, sunk_cnt=5, err_cnt=1; game_over=1 one cycle after the fifth S.
REQ-043 Inject 300 'M' strobes -> miss_cnt=255 and holds there.
REQ-044 tx_busy held 0 after a tx_start -> tx_fault=1 and state IDLE 16 cycles after the pulse; no second tx_start.
REQ-045 Assert rst at byte 50 of the stream, then start -> stream restarts at rom_addr=0; the total pulse count after the restart is 144.
REQ-046 In LISTEN, start coincident with an 'H' strobe -> hit_cnt=0, streaming=1, first tx_start 3 cycles later.
